regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//  Architectural 32x32 general register file; the consumer end of the MEM_WB write-back interface.
//  Commits the MEM_WB we/waddr/wdata write each cycle and serves two combinational read ports to ID.
//  Also counts retired (non-bubble) instructions using the inst word carried through MEM_WB.
// PARAMETERS
//  NUM_REGS   32  number of registers; must equal 2**ADDR_W
//  ADDR_W     5   register address width
//  DATA_W     32  register data width
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       asynchronous, active-low reset
//  we          in   1       write enable from MEM_WB
//  waddr       in   ADDR_W  write address from MEM_WB
//  wdata       in   DATA_W  write data from MEM_WB
//  inst_i      in   32      instruction word from MEM_WB (32'h0 = bubble)
//  re1         in   1       read enable, port 1 (ID rs)
//  raddr1      in   ADDR_W  read address, port 1
//  rdata1      out  DATA_W  read data, port 1
//  re2         in   1       read enable, port 2 (ID rt)
//  raddr2      in   ADDR_W  read address, port 2
//  rdata2      out  DATA_W  read data, port 2
//  retire_cnt  out  32      retired-instruction counter (registered)
//  wb_done     out  1       registered pulse: a write committed last cycle
// BEHAVIOUR
//  - Reset (rst=0, async): all NUM_REGS entries <= 0, retire_cnt <= 0, wb_done <= 0;
//    rdata1/rdata2 forced to 0 while rst=0. Reset during a write cancels that write.
//  - Write: at posedge, if we=1 and waddr!=0, regs[waddr] <= wdata. The 1-cycle write latency is
//    measured from MEM_WB output valid to array update.
//  - Register 0 is hardwired to zero: writes to it are dropped, and reads always return 0.
//  - Read (combinational, 0 latency): rdataN = 0 if rst=0, reN=0, or raddrN=0; else regs[raddrN].
//  - Same-cycle read/write collision: the result depends on WB_BYPASS_EN (see CONFIGURATION).
//  - Both ports reading the same address are independent and return identical data.
//  - wb_done <= (we && waddr!=0) each posedge; it is a one-cycle pulse per committed write.
//  - retire_cnt increments by 1 at posedge when inst_i != 32'h0; it wraps from 32'hFFFF_FFFF to 0.
//    A bubble with we=0 does not count. A non-zero inst with we=0 (store/branch) does count.
// CONFIGURATION
//  `define REGFILE_BYPASS_EN:
//    - defined: if reN=1, raddrN==waddr, we=1 and waddr!=0, then rdataN = wdata in the same cycle
//      (write-through). This covers the WB->ID hazard with no stall.
//    - undefined: rdataN returns the pre-write array value. Ctrl must stall ID one extra cycle on a
//      WB->ID dependency.
// STRUCTURE
//  - define.v additions: RegNum=32, RegAddrBus=4:0, RegBus=31:0, RstnEnable=1'b0.
//    Reuse ZeroWord, WriteEnable, ReadEnable.
//  - Sub-module regfile_rd_port: zero/enable gating plus the optional bypass mux.
//    It is instantiated twice (port 1, port 2). Array, counter and wb_done live in the top module.
// TESTING
//  1. Reset: assert rst=0 mid-run -> rdata1=rdata2=0 and retire_cnt=0 immediately. Then read every
//     reg after release -> 0.
//  2. Write/read: we=1, waddr=5, wdata=32'hDEAD_BEEF -> next cycle re1=1, raddr1=5 gives
//     32'hDEAD_BEEF, and wb_done=1 for exactly one cycle.
//  3. $0: we=1, waddr=0, wdata=32'h1234 -> raddr1=0 reads 0, and wb_done stays 0.
//  4. Collision: reg 7 = 32'h1; same cycle we=1, waddr=7, wdata=32'h2, raddr2=7 ->
//     rdata2=32'h2 with REGFILE_BYPASS_EN, 32'h1 without it. Next cycle it reads 32'h2 in both builds.
//  5. Read enable: re1=0, raddr1=5 (reg 5 = 32'hDEAD_BEEF) -> rdata1=0.
//     re2=1, raddr2=5 in the same cycle -> 32'hDEAD_BEEF.
//  6. Retire counter: 10 cycles of inst_i with 3 bubbles (32'h0) -> retire_cnt=7.
//     Force the counter to 32'hFFFF_FFFF, then one non-zero inst -> 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back register file.
// Polarity constants name the active level of the reset, write-enable and read-enable inputs.
package regfile_wb_pkg;

  localparam int unsigned RegNum   = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;

  localparam logic [RegDataW-1:0] ZeroWord    = '0;
  localparam logic                WriteEnable = 1'b1;
  localparam logic                ReadEnable  = 1'b1;
  localparam logic                RstnEnable  = 1'b0;

endpackage

// File: rtl/regfile_wb_rd_port.sv
// One combinational read port of the register file.
// Returns zero while in reset, when the port is disabled, or when register 0 is addressed.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
// Ports:
//   rst_ni     async active-low reset (gates the output to zero while low)
//   re_i       read enable
//   raddr_i    read address
//   arr_data_i array contents at raddr_i
//   we_i       write enable of the write-back port
//   waddr_i    write address of the write-back port
//   wdata_i    write data of the write-back port
//   rdata_o    read data
module regfile_wb_rd_port
  import regfile_wb_pkg::*;
#(
  parameter int unsigned AddrW = RegAddrW,
  parameter int unsigned DataW = RegDataW
) (
  input  logic             rst_ni,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  input  logic [DataW-1:0] arr_data_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs only feed the bypass mux.
  logic unused_bypass;
  assign unused_bypass = ^{we_i, waddr_i, wdata_i};
`endif

  always_comb begin
    rdata_o = '0;
    if (rst_ni == RstnEnable || re_i != ReadEnable || raddr_i == '0) begin
      rdata_o = '0;
`ifdef REGFILE_BYPASS_EN
    // raddr_i != 0 here, so the match also implies waddr_i != 0.
    end else if (we_i == WriteEnable && raddr_i == waddr_i) begin
      rdata_o = wdata_i;
`endif
    end else begin
      rdata_o = arr_data_i;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Architectural general register file at the consumer end of the MEM_WB interface.
// Commits one write per cycle, serves two combinational read ports, counts retired
// (non-bubble) instructions and pulses wb_done_o the cycle after each committed write.
// Optional build macro: REGFILE_BYPASS_EN enables write-through on same-cycle read/write.
// Ports:
//   clk_i        clock
//   rst_ni       async active-low reset
//   we_i         write enable
//   waddr_i      write address
//   wdata_i      write data
//   inst_i       instruction word (zero marks a bubble)
//   re1_i        read enable, port 1
//   raddr1_i     read address, port 1
//   rdata1_o     read data, port 1
//   re2_i        read enable, port 2
//   raddr2_i     read address, port 2
//   rdata2_o     read data, port 2
//   retire_cnt_o retired-instruction counter
//   wb_done_o    pulse: a write committed on the previous edge
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NumRegs = RegNum,
  parameter int unsigned AddrW   = RegAddrW,
  parameter int unsigned DataW   = RegDataW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [31:0]      inst_i,
  input  logic             re1_i,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [DataW-1:0] rdata1_o,
  input  logic             re2_i,
  input  logic [AddrW-1:0] raddr2_i,
  output logic [DataW-1:0] rdata2_o,
  output logic [31:0]      retire_cnt_o,
  output logic             wb_done_o
);

  logic [DataW-1:0] regs_q [NumRegs];
  logic [31:0]      retire_cnt_q, retire_cnt_d;
  logic             wb_done_q, wb_done_d;
  logic             commit;

  // Writes to register 0 are dropped so it always reads back as zero.
  assign commit = (we_i == WriteEnable) && (waddr_i != '0);

  always_comb begin
    wb_done_d    = commit;
    retire_cnt_d = retire_cnt_q;
    if (inst_i != 32'h0) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
      wb_done_q    <= 1'b0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      wb_done_q    <= wb_done_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
  assign wb_done_o    = wb_done_q;

  regfile_wb_rd_port #(
    .AddrW(AddrW),
    .DataW(DataW)
  ) u_rd_port1 (
    .rst_ni    (rst_ni),
    .re_i      (re1_i),
    .raddr_i   (raddr1_i),
    .arr_data_i(regs_q[raddr1_i]),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata1_o)
  );

  regfile_wb_rd_port #(
    .AddrW(AddrW),
    .DataW(DataW)
  ) u_rd_port2 (
    .rst_ni    (rst_ni),
    .re_i      (re2_i),
    .raddr_i   (raddr2_i),
    .arr_data_i(regs_q[raddr2_i]),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata2_o)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
module tb_regfile_wb;

  logic        clk_i;
  logic        rst_ni;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [31:0] inst_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic [31:0] retire_cnt_o;
  logic        wb_done_o;

  int n_checks;
  int n_fails;

  regfile_wb dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .inst_i      (inst_i),
    .re1_i       (re1_i),
    .raddr1_i    (raddr1_i),
    .rdata1_o    (rdata1_o),
    .re2_i       (re2_i),
    .raddr2_i    (raddr2_i),
    .rdata2_o    (rdata2_o),
    .retire_cnt_o(retire_cnt_o),
    .wb_done_o   (wb_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] inst_seq [10];
  logic [31:0] collide_exp;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_ni   = 1'b0;
    we_i     = 1'b0;
    waddr_i  = '0;
    wdata_i  = '0;
    inst_i   = '0;
    re1_i    = 1'b0;
    raddr1_i = '0;
    re2_i    = 1'b0;
    raddr2_i = '0;

    // Power-on reset.
    #12;
    chk("por_cnt", retire_cnt_o, 32'h0);
    chk("por_wb_done", {31'h0, wb_done_o}, 32'h0);
    rst_ni = 1'b1;
    step();

    // Write/read on reg 5 with one retiring instruction.
    we_i    = 1'b1;
    waddr_i = 5'd5;
    wdata_i = 32'hDEAD_BEEF;
    inst_i  = 32'h0000_0013;
    step();
    we_i     = 1'b0;
    inst_i   = 32'h0;
    re1_i    = 1'b1;
    raddr1_i = 5'd5;
    #1;
    chk("wr_rd1", rdata1_o, 32'hDEAD_BEEF);
    chk("wb_done_pulse", {31'h0, wb_done_o}, 32'h1);
    chk("cnt_after_one", retire_cnt_o, 32'h1);
    step();
    chk("wb_done_clear", {31'h0, wb_done_o}, 32'h0);

    // Writes to register 0 are dropped.
    we_i    = 1'b1;
    waddr_i = 5'd0;
    wdata_i = 32'h0000_1234;
    step();
    we_i     = 1'b0;
    raddr1_i = 5'd0;
    #1;
    chk("r0_read", rdata1_o, 32'h0);
    chk("r0_wb_done", {31'h0, wb_done_o}, 32'h0);

    // Same-cycle read/write collision on reg 7.
    we_i    = 1'b1;
    waddr_i = 5'd7;
    wdata_i = 32'h1;
    step();
    wdata_i  = 32'h2;
    re2_i    = 1'b1;
    raddr2_i = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    collide_exp = 32'h2;
`else
    collide_exp = 32'h1;
`endif
    chk("collide_same_cycle", rdata2_o, collide_exp);
    step();
    we_i = 1'b0;
    #1;
    chk("collide_next_cycle", rdata2_o, 32'h2);

    // Read enables and both ports on one address.
    re1_i    = 1'b0;
    raddr1_i = 5'd5;
    raddr2_i = 5'd5;
    #1;
    chk("re1_off", rdata1_o, 32'h0);
    chk("re2_on", rdata2_o, 32'hDEAD_BEEF);
    re1_i = 1'b1;
    #1;
    chk("dual_port1", rdata1_o, 32'hDEAD_BEEF);
    chk("dual_port2", rdata2_o, 32'hDEAD_BEEF);

    // Mid-run async reset with a write pending; the write must be cancelled.
    we_i    = 1'b1;
    waddr_i = 5'd9;
    wdata_i = 32'hCAFE_F00D;
    inst_i  = 32'h0000_0033;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_rdata1", rdata1_o, 32'h0);
    chk("rst_rdata2", rdata2_o, 32'h0);
    chk("rst_cnt", retire_cnt_o, 32'h0);
    step();
    we_i   = 1'b0;
    inst_i = 32'h0;
    rst_ni = 1'b1;
    #1;
    chk("rst_wb_done", {31'h0, wb_done_o}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1_i = 5'(i);
      raddr2_i = 5'(31 - i);
      #1;
      chk($sformatf("rst_clear_p1_r%0d", i), rdata1_o, 32'h0);
      chk($sformatf("rst_clear_p2_r%0d", 31 - i), rdata2_o, 32'h0);
    end

    // Retire counter: 10 cycles, 3 bubbles.
    inst_seq = '{32'h13, 32'h0, 32'h33, 32'h0, 32'h93,
                 32'h1, 32'h2, 32'h0, 32'h5, 32'h6};
    for (int i = 0; i < 10; i++) begin
      inst_i = inst_seq[i];
      step();
    end
    inst_i = 32'h0;
    #1;
    chk("retire_7", retire_cnt_o, 32'h7);
    step();
    chk("retire_bubble_hold", retire_cnt_o, 32'h7);

    // Counter wrap from all-ones.
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    chk("cnt_forced", retire_cnt_o, 32'hFFFF_FFFF);
    inst_i = 32'h0000_0013;
    step();
    inst_i = 32'h0;
    #1;
    chk("cnt_wrap", retire_cnt_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
